spi_reg_master: RTL and testbench

//  Host-side SPI master for the flight controller register port: the initiator end of the link FLIGHT_CTRL_TOP serves.

---
 rtl/spi_reg_master.sv | 179 +++++++++++++++++
 tb/tb_spi_reg_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// spi_reg_master: host-side SPI mode-0 master issuing one register transaction
// per start request. Frame = {wen, addr[6:0]} followed by size data bytes,
// MSB first. Write bytes are pulled from wdata_i with a one-cycle wdata_rd_o
// handshake; read bytes are returned on rdata_o with a one-cycle rdata_valid_o.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CSN high, SCLK low, waiting for start_i
// LEAD  | one half period with CSN low and SCLK low before the first edge
// SHIFT | SCLK toggles every half period; 16 half periods per byte
// TRAIL | one half period with SCLK low after the last falling edge
// GAP   | one half period with CSN high, then DONE and back to IDLE
`timescale 1ns/1ps
module spi_reg_master #(
    parameter int CLK_DIV = 2,
    parameter int SIZE_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              wen_i,
    input  logic [6:0]        addr_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [7:0]        wdata_i,
    output logic              wdata_rd_o,
    output logic [7:0]        rdata_o,
    output logic              rdata_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_csn_o
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        tx_q;      // tx_q[7] is the bit currently on MOSI
    logic [7:0]        rx_q;
    logic [2:0]        bit_q;
    logic [SIZE_W-1:0] left_q;
    logic              wen_q;
    logic              addr_ph_q; // current byte is the address byte
    logic              sclk_q;
    logic              csn_q;
    logic              busy_q;
    logic              done_q;
    logic              wrd_q;
    logic              rvld_q;
    logic [7:0]        rdata_q;
    logic              tick;

    assign tick = (state_q != IDLE) && (cnt_q == CNT_MAX);

    // Half-period counter: free-runs outside IDLE, wraps on every tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Transaction FSM with registered serial outputs and handshake pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            left_q    <= '0;
            wen_q     <= 1'b0;
            addr_ph_q <= 1'b0;
            sclk_q    <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrd_q     <= 1'b0;
            rvld_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wrd_q  <= 1'b0;
            rvld_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        wen_q     <= wen_i;
                        left_q    <= size_i;
                        tx_q      <= {wen_i, addr_i};
                        bit_q     <= '0;
                        addr_ph_q <= 1'b1;
                        sclk_q    <= 1'b0;
                        csn_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[6:0], spi_miso_i};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q != 3'd7) begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= {tx_q[6:0], 1'b0};
                            end else begin
                                bit_q     <= '0;
                                addr_ph_q <= 1'b0;
                                if (!wen_q && !addr_ph_q) begin
                                    rdata_q <= rx_q;
                                    rvld_q  <= 1'b1;
                                end
                                if (left_q != '0) begin
                                    left_q <= left_q - SIZE_W'(1);
                                    if (wen_q) begin
                                        tx_q  <= wdata_i;
                                        wrd_q <= 1'b1;
                                    end else begin
                                        tx_q <= 8'h00;
                                    end
                                end else begin
                                    tx_q    <= 8'h00;
                                    state_q <= TRAIL;
                                end
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        csn_q   <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wdata_rd_o    = wrd_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvld_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spi_clk_o     = sclk_q;
    assign spi_mosi_o    = tx_q[7];
    assign spi_csn_o     = csn_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: directed bench for spi_reg_master. Two instances share
// clock and reset: u_dut0 with CLK_DIV=2 and u_dut1 with CLK_DIV=1. A mode-0
// slave with a 128-byte register file sits on each link.
`timescale 1ns/1ps
module tb_spi_reg_master;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        start [2];
    logic        wen   [2];
    logic [6:0]  addr  [2];
    logic [11:0] size  [2];
    logic [7:0]  wdata [2];
    logic        wrd   [2];
    logic [7:0]  rdata [2];
    logic        rvld  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sclk  [2];
    logic        mosi  [2];
    logic        miso  [2];
    logic        csn   [2];

    spi_reg_master #(.CLK_DIV(2), .SIZE_W(12)) u_dut0 (
        .clk_i(clk_sys), .rst_ni(rst_n), .start_i(start[0]), .wen_i(wen[0]),
        .addr_i(addr[0]), .size_i(size[0]), .wdata_i(wdata[0]), .wdata_rd_o(wrd[0]),
        .rdata_o(rdata[0]), .rdata_valid_o(rvld[0]), .busy_o(busy[0]), .done_o(done[0]),
        .spi_clk_o(sclk[0]), .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]), .spi_csn_o(csn[0])
    );

    spi_reg_master #(.CLK_DIV(1), .SIZE_W(12)) u_dut1 (
        .clk_i(clk_sys), .rst_ni(rst_n), .start_i(start[1]), .wen_i(wen[1]),
        .addr_i(addr[1]), .size_i(size[1]), .wdata_i(wdata[1]), .wdata_rd_o(wrd[1]),
        .rdata_o(rdata[1]), .rdata_valid_o(rvld[1]), .busy_o(busy[1]), .done_o(done[1]),
        .spi_clk_o(sclk[1]), .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]), .spi_csn_o(csn[1])
    );

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int         rises [2], first_rise [2], last_rise [2];
    int         n_wrd [2], n_rv [2], n_done [2], n_clash [2], n_mosi [2], widx [2];
    logic [7:0] mosi_log [2][16];
    logic [7:0] rd_log   [2][16];
    logic [7:0] wbuf     [2][8];
    logic [7:0] mem      [2][128];
    logic       prev     [2];
    int         sbit [2], sbyte [2];
    logic [7:0] shin [2], hdr [2], txsh [2];
    logic [6:0] sa;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk_sys);
        cyc++;
    end

    // Monitors and slave models, evaluated away from the active edge.
    initial begin
        forever begin
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                if (wrd[i]) begin
                    n_wrd[i]++;
                    widx[i]++;
                    wdata[i] = wbuf[i][widx[i] % 8];
                end
                if (rvld[i]) begin
                    if (n_rv[i] < 16) rd_log[i][n_rv[i]] = rdata[i];
                    n_rv[i]++;
                end
                if (done[i]) n_done[i]++;
                if (done[i] && (wrd[i] || rvld[i])) n_clash[i]++;

                if (csn[i]) begin
                    sbit[i]  = 0;
                    sbyte[i] = 0;
                    miso[i]  = 1'b0;
                end else if (sclk[i] && !prev[i]) begin
                    if (rises[i] == 0) first_rise[i] = cyc;
                    last_rise[i] = cyc;
                    rises[i]++;
                    shin[i] = {shin[i][6:0], mosi[i]};
                    sbit[i]++;
                    if (sbit[i] == 8) begin
                        sbit[i] = 0;
                        if (n_mosi[i] < 16) mosi_log[i][n_mosi[i]] = shin[i];
                        n_mosi[i]++;
                        if (sbyte[i] == 0) begin
                            hdr[i] = shin[i];
                        end else if (hdr[i][7]) begin
                            sa = hdr[i][6:0] + 7'(sbyte[i] - 1);
                            mem[i][sa] = shin[i];
                        end
                        sbyte[i]++;
                    end
                end else if (!sclk[i] && prev[i]) begin
                    if (sbit[i] == 0) begin
                        if (sbyte[i] > 0 && !hdr[i][7]) begin
                            sa = hdr[i][6:0] + 7'(sbyte[i] - 1);
                            txsh[i] = mem[i][sa];
                        end else begin
                            txsh[i] = 8'h00;
                        end
                    end else begin
                        txsh[i] = {txsh[i][6:0], 1'b0};
                    end
                    miso[i] = txsh[i][7];
                end
                prev[i] = sclk[i];
            end
        end
    end

    task automatic drive_start(input int i, input logic w, input logic [6:0] a,
                               input logic [11:0] s, output int t0);
        n_mosi[i] = 0; rises[i] = 0; n_wrd[i] = 0; n_rv[i] = 0;
        n_done[i] = 0; n_clash[i] = 0; widx[i] = 0;
        wdata[i] = wbuf[i][0];
        wen[i] = w; addr[i] = a; size[i] = s; start[i] = 1'b1;
        t0 = cyc;
        @(posedge clk_sys); #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int t0, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_sys); #1;
            if (done[i]) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    int t0, lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; wen[i] = 0; addr[i] = 0; size[i] = 0; wdata[i] = 0;
            miso[i] = 0; prev[i] = 0; sbit[i] = 0; sbyte[i] = 0;
            shin[i] = 0; hdr[i] = 0; txsh[i] = 0; rises[i] = 0;
            first_rise[i] = 0; last_rise[i] = 0; n_wrd[i] = 0; n_rv[i] = 0;
            n_done[i] = 0; n_clash[i] = 0; n_mosi[i] = 0; widx[i] = 0;
            for (int k = 0; k < 128; k++) mem[i][k] = 8'h00;
            for (int k = 0; k < 8; k++) wbuf[i][k] = 8'h00;
            for (int k = 0; k < 16; k++) begin mosi_log[i][k] = 0; rd_log[i][k] = 0; end
        end

        // Reset state
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctl%0d", i),
                {25'd0, csn[i], sclk[i], mosi[i], busy[i], done[i], wrd[i], rvld[i]},
                32'b1000000);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        // 1: write ADDR=4 SIZE=1 WDATA=4
        wbuf[0][0] = 8'd4;
        drive_start(0, 1'b1, 7'd4, 12'd1, t0);
        chk("t1_busy_csn", {busy[0], csn[0]}, 2'b10);
        wait_done(0, t0, 200, lat);
        chk("t1_latency", lat, 71);
        chk("t1_busy_done_cycle", busy[0], 0);
        chk("t1_mosi0", mosi_log[0][0], 8'h84);
        chk("t1_mosi1", mosi_log[0][1], 8'h04);
        chk("t1_rises", rises[0], 16);
        chk("t1_rise_span", last_rise[0] - first_rise[0], 60);
        chk("t1_wdata_rd", n_wrd[0], 1);
        chk("t1_rvld", n_rv[0], 0);
        chk("t1_mem4", mem[0][4], 8'd4);

        // 2: read ADDR=44 SIZE=1, slave returns 0x2A
        mem[0][44] = 8'h2A;
        @(posedge clk_sys); #1;
        drive_start(0, 1'b0, 7'd44, 12'd1, t0);
        wait_done(0, t0, 200, lat);
        chk("t2_latency", lat, 71);
        chk("t2_mosi0", mosi_log[0][0], 8'h2C);
        chk("t2_mosi1", mosi_log[0][1], 8'h00);
        chk("t2_rvld", n_rv[0], 1);
        chk("t2_rdata", rd_log[0][0], 8'h2A);
        chk("t2_wdata_rd", n_wrd[0], 0);

        // 3: burst write then burst read ADDR=15 SIZE=5
        for (int k = 0; k < 5; k++) wbuf[0][k] = 8'(90 + 10 * k);
        @(posedge clk_sys); #1;
        drive_start(0, 1'b1, 7'd15, 12'd5, t0);
        wait_done(0, t0, 400, lat);
        chk("t3w_latency", lat, 199);
        chk("t3w_wdata_rd", n_wrd[0], 5);
        chk("t3w_rvld", n_rv[0], 0);
        chk("t3w_clash", n_clash[0], 0);
        for (int k = 0; k < 5; k++) chk($sformatf("t3w_mem%0d", 15 + k), mem[0][15 + k], 90 + 10 * k);
        @(posedge clk_sys); #1;
        drive_start(0, 1'b0, 7'd15, 12'd5, t0);
        wait_done(0, t0, 400, lat);
        chk("t3r_latency", lat, 199);
        chk("t3r_rvld", n_rv[0], 5);
        chk("t3r_wdata_rd", n_wrd[0], 0);
        chk("t3r_clash", n_clash[0], 0);
        for (int k = 0; k < 5; k++) chk($sformatf("t3r_rd%0d", k), rd_log[0][k], 90 + 10 * k);

        // 4: SIZE=0 write ADDR=5, with an ignored START mid-transfer
        @(posedge clk_sys); #1;
        drive_start(0, 1'b1, 7'd5, 12'd0, t0);
        repeat (12) @(posedge clk_sys);
        #1;
        wen[0] = 1'b1; addr[0] = 7'h7F; size[0] = 12'd3; start[0] = 1'b1;
        @(posedge clk_sys); #1;
        start[0] = 1'b0;
        wait_done(0, t0, 200, lat);
        chk("t4_latency", lat, 39);
        chk("t4_rises", rises[0], 8);
        chk("t4_mosi0", mosi_log[0][0], 8'h85);
        chk("t4_wdata_rd", n_wrd[0], 0);
        repeat (60) @(negedge clk_sys);
        chk("t4_single_done", n_done[0], 1);
        chk("t4_idle_busy", busy[0], 0);

        // 5: reset in the middle of a read data byte
        @(posedge clk_sys); #1;
        drive_start(0, 1'b0, 7'd44, 12'd1, t0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_sys); #1;
            if (rises[0] >= 11) break;
        end
        chk("t5_mid_byte", rises[0] >= 11, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_csn_sclk", {csn[0], sclk[0]}, 2'b10);
        chk("t5_rdata_cleared", rdata[0], 0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_sys);
        chk("t5_no_done", n_done[0], 0);
        chk("t5_no_rvld", n_rv[0], 0);
        mem[0][5] = 8'h11;
        mem[0][6] = 8'h22;
        @(posedge clk_sys); #1;
        drive_start(0, 1'b0, 7'd5, 12'd2, t0);
        wait_done(0, t0, 300, lat);
        chk("t5_latency", lat, 103);
        chk("t5_rvld", n_rv[0], 2);
        chk("t5_rd0", rd_log[0][0], 8'h11);
        chk("t5_rd1", rd_log[0][1], 8'h22);

        // 6: CLK_DIV=1 read ADDR=0 SIZE=5, back-to-back START in DONE cycle
        for (int k = 0; k < 5; k++) mem[1][k] = 8'(8'hA1 + k);
        @(posedge clk_sys); #1;
        drive_start(1, 1'b0, 7'd0, 12'd5, t0);
        wait_done(1, t0, 300, lat);
        chk("t6_latency", lat, 100);
        chk("t6_rvld", n_rv[1], 5);
        chk("t6_rises", rises[1], 48);
        chk("t6_rise_span", last_rise[1] - first_rise[1], 94);
        chk("t6_clash", n_clash[1], 0);
        for (int k = 0; k < 5; k++) chk($sformatf("t6_rd%0d", k), rd_log[1][k], 8'hA1 + k);
        drive_start(1, 1'b0, 7'd0, 12'd1, t0);
        chk("t6b_busy", busy[1], 1);
        wait_done(1, t0, 200, lat);
        chk("t6b_latency", lat, 36);
        chk("t6b_rvld", n_rv[1], 1);
        chk("t6b_rd0", rd_log[1][0], 8'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
